div_restoring_iter: RTL and testbench

- Iterative radix-2 restoring integer divider for the RV64 execute stage.
- Accepts one operand pair per request, performs one subtract/restore step per cycle, and returns quotient and remainder through a valid/ready handshake.
- Implements RISC-V M-extension semantics for DIV/DIVU/REM/REMU, including divide-by-zero and signed overflow.
- The W-variants are handled outside this block, by sign/zero-extension before the request.

---
 rtl/div_restoring_iter_pkg.sv | 22 ++
 rtl/div_sub_step.sv | 25 ++
 rtl/div_restoring_iter.sv | 163 ++++++++++++++++
 tb/tb_div_restoring_iter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/div_restoring_iter_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state
// encoding, the divide-by-zero quotient and the signed-minimum helper.
package div_restoring_iter_pkg;

  // Widest operand the helpers below can describe; the top narrows them.
  localparam int DIV_MAX_W = 128;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Quotient returned for a zero divisor: all ones at any width.
  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_Q = '1;

  // Most negative two's-complement value of a w-bit word (only bit w-1 set).
  function automatic logic [DIV_MAX_W-1:0] div_signed_min(input int w);
    div_signed_min = DIV_MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor magnitude, keep or restore.
module div_sub_step #(
  parameter int DATA_LEN = 64
) (
  input  logic [DATA_LEN-1:0] rem_in,
  input  logic                bit_in,
  input  logic [DATA_LEN-1:0] dvs_mag,
  output logic [DATA_LEN-1:0] rem_out,
  output logic                q_bit
);

  // rem_in is always below dvs_mag, so the shifted remainder is below
  // 2*dvs_mag. A DATA_LEN+1-bit difference therefore has a clear MSB when
  // the trial succeeds and a set MSB when it borrows.
  logic [DATA_LEN:0] trial;

  // Trial subtract and select kept or restored remainder.
  always_comb begin
    trial   = {rem_in, bit_in} - {1'b0, dvs_mag};
    q_bit   = ~trial[DATA_LEN];
    rem_out = q_bit ? trial[DATA_LEN-1:0] : {rem_in[DATA_LEN-2:0], bit_in};
  end

endmodule

// File: rtl/div_restoring_iter.sv
// Iterative radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU results.
// Optional macro DIV_EARLY_OUT_EN: skip iterations when |divisor| > |dividend|.
// DATA_LEN must lie in 2..128.
module div_restoring_iter
  import div_restoring_iter_pkg::*;
#(
  parameter int DATA_LEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic [DATA_LEN-1:0] dividend,
  input  logic [DATA_LEN-1:0] divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_LEN);
  localparam logic [DATA_LEN-1:0] SMIN   = DATA_LEN'(div_signed_min(DATA_LEN));
  localparam logic [DATA_LEN-1:0] ZERO_Q = DATA_LEN'(DIV_ZERO_Q);
  localparam logic [CNT_W-1:0]    LAST   = CNT_W'(DATA_LEN - 1);

  div_state_e          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                dvd_neg_reg, dvd_neg_next;   // remainder sign
  logic                neg_q_reg, neg_q_next;       // quotient needs negation
  logic [DATA_LEN-1:0] dvs_mag_reg, dvs_mag_next;
  logic [DATA_LEN-1:0] dvd_sh_reg, dvd_sh_next;     // dividend out at MSB, quotient in at LSB
  logic [DATA_LEN-1:0] rem_reg, rem_next;
  logic [DATA_LEN-1:0] quotient_reg, quotient_next;
  logic [DATA_LEN-1:0] remainder_reg, remainder_next;

  // Accept-side operand decode.
  logic                dvd_neg, dvs_neg, div_zero, ovf, early;
  logic [DATA_LEN-1:0] dvd_mag, dvs_mag;

  // Iteration datapath.
  logic [DATA_LEN-1:0] step_rem;
  logic                step_q;
  logic [DATA_LEN-1:0] q_raw;

  div_sub_step #(.DATA_LEN(DATA_LEN)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (dvd_sh_reg[DATA_LEN-1]),
    .dvs_mag (dvs_mag_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Operand signs, magnitudes and the short-circuit cases seen at accept.
  always_comb begin
    dvd_neg  = in_signed & dividend[DATA_LEN-1];
    dvs_neg  = in_signed & divisor[DATA_LEN-1];
    dvd_mag  = dvd_neg ? -dividend : dividend;
    dvs_mag  = dvs_neg ? -divisor : divisor;
    div_zero = (divisor == '0);
    ovf      = in_signed && (dividend == SMIN) && (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
    early    = (dvs_mag > dvd_mag);
`else
    early    = 1'b0;
`endif
  end

  // Next-state and datapath update; flush overrides every transition.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    dvd_neg_next   = dvd_neg_reg;
    neg_q_next     = neg_q_reg;
    dvs_mag_next   = dvs_mag_reg;
    dvd_sh_next    = dvd_sh_reg;
    rem_next       = rem_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    q_raw          = {dvd_sh_reg[DATA_LEN-2:0], step_q};

    case (state_reg)
      DIV_IDLE: begin
        if (in_valid) begin
          dvd_neg_next = dvd_neg;
          neg_q_next   = dvd_neg ^ dvs_neg;
          dvs_mag_next = dvs_mag;
          dvd_sh_next  = dvd_mag;
          rem_next     = '0;
          cnt_next     = '0;
          if (div_zero) begin
            quotient_next  = ZERO_Q;
            remainder_next = dividend;
            state_next     = DIV_DONE;
          end else if (ovf) begin
            quotient_next  = dividend;
            remainder_next = '0;
            state_next     = DIV_DONE;
          end else if (early) begin
            quotient_next  = '0;
            remainder_next = dividend;
            state_next     = DIV_DONE;
          end else begin
            state_next = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_next    = step_rem;
        dvd_sh_next = q_raw;
        if (cnt_reg == LAST) begin
          quotient_next  = neg_q_reg ? -q_raw : q_raw;
          remainder_next = dvd_neg_reg ? -step_rem : step_rem;
          state_next     = DIV_DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DIV_DONE: begin
        if (out_ready) begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase

    if (flush) begin
      state_next = DIV_IDLE;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= DIV_IDLE;
      cnt_reg       <= '0;
      dvd_neg_reg   <= 1'b0;
      neg_q_reg     <= 1'b0;
      dvs_mag_reg   <= '0;
      dvd_sh_reg    <= '0;
      rem_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      dvd_neg_reg   <= dvd_neg_next;
      neg_q_reg     <= neg_q_next;
      dvs_mag_reg   <= dvs_mag_next;
      dvd_sh_reg    <= dvd_sh_next;
      rem_reg       <= rem_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
    end
  end

  assign in_ready  = (state_reg == DIV_IDLE);
  assign out_valid = (state_reg == DIV_DONE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: tb/tb_div_restoring_iter.sv
// Directed, table-driven bench for div_restoring_iter at DATA_LEN=64.
module tb_div_restoring_iter;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_signed, out_ready;
  logic [63:0] dividend, divisor;
  logic        in_ready, out_valid;
  logic [63:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 65;
`endif

  typedef struct {
    string       name;
    logic        sgn;
    logic [63:0] dvd;
    logic [63:0] dvs;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  div_restoring_iter #(.DATA_LEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for in_ready, then present one request for one edge.
  task automatic issue(input logic sgn, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_ready", {63'd0, in_ready}, 64'd1);
    in_valid  = 1'b1;
    in_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  // Latency counts the accept edge as 1.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Watch for any out_valid over n cycles.
  task automatic watch_quiet(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{"u_100_7",     1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65};
    vecs[1]  = '{"s_m100_7",    1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
                 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{"s_100_m7",    1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
                 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 65};
    vecs[3]  = '{"s_m100_m7",   1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
                 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[4]  = '{"u_div0",      1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1};
    vecs[5]  = '{"s_div0",      1'b1, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1};
    vecs[6]  = '{"s_ovf",       1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 64'd0, 1};
    vecs[7]  = '{"u_5_9",       1'b0, 64'd5, 64'd9, 64'd0, 64'd5, SMALL_LAT};
    vecs[8]  = '{"u_max_1",     1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
    vecs[9]  = '{"u_max_maxm1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
                 64'd1, 64'd1, 65};
    vecs[10] = '{"s_m7_100",    1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100,
                 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, SMALL_LAT};
    vecs[11] = '{"u_min_max",   1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'd0, 64'h8000_0000_0000_0000, SMALL_LAT};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_quotient",  quotient,  64'd0);
    chk("rst_remainder", remainder, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of directed vectors.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].sgn, vecs[i].dvd, vecs[i].dvs);
      wait_result(lat);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
      chk({vecs[i].name, "_q"}, quotient, vecs[i].q);
      chk({vecs[i].name, "_r"}, remainder, vecs[i].r);
      take();
      chk({vecs[i].name, "_handoff"}, {62'd0, in_ready, out_valid}, 64'd2);
      $display("vec %s: q=%h r=%h lat=%0d", vecs[i].name, vecs[i].q, vecs[i].r, lat);
    end

    // Backpressure: result held for 10 cycles with out_ready low.
    issue(1'b0, 64'd100, 64'd7);
    wait_result(lat);
    chk("bp_lat", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {quotient[61:0], out_valid, in_ready}, {62'd14, 2'b10});
      chk("bp_rem", remainder, 64'd2);
    end
    take();
    $display("backpressure: held 10 cycles");

    // Flush at CALC iteration 30.
    issue(1'b0, 64'd1000, 64'd3);
    repeat (29) @(posedge clk);
    #1;
    chk("fl_busy", {62'd0, in_ready, out_valid}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_idle", {62'd0, in_ready, out_valid}, 64'd2);
    watch_quiet("fl_quiet", 70);
    issue(1'b0, 64'd9, 64'd3);
    wait_result(lat);
    chk("after_fl_lat", 64'(lat), 64'd65);
    chk("after_fl_q", quotient, 64'd3);
    chk("after_fl_r", remainder, 64'd0);
    take();
    $display("flush in CALC then 9/3: q=%h r=%h", quotient, remainder);

    // Flush together with in_valid in IDLE: request must be dropped.
    in_valid = 1'b1; flush = 1'b1; in_signed = 1'b0; dividend = 64'd9; divisor = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_noacc", {63'd0, in_ready}, 64'd1);
    watch_quiet("fl_idle_quiet", 70);
    $display("flush with in_valid in IDLE: dropped");

    // Flush while a result waits in DONE.
    issue(1'b0, 64'h1234, 64'd0);
    wait_result(lat);
    chk("fl_done_lat", 64'(lat), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_done_idle", {62'd0, in_ready, out_valid}, 64'd2);
    watch_quiet("fl_done_quiet", 5);
    $display("flush in DONE: result discarded");

    // Reset in the middle of an operation.
    issue(1'b0, 64'd100, 64'd7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_state", {62'd0, in_ready, out_valid}, 64'd2);
    chk("mid_rst_q", quotient, 64'd0);
    chk("mid_rst_r", remainder, 64'd0);
    rst_n = 1'b1;
    watch_quiet("mid_rst_quiet", 70);
    $display("reset mid-operation: back to reset values");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
